// File: rtl/serv_wb_arbiter_if.sv
// Bus bundle for serv_wb_arbiter: the SERV ibus/dbus requester ports, the shared
// Wishbone master port and the timeout pulse. The arbiter takes the master
// modport. The environment (core, memory or bench) takes the slave modport.
interface serv_wb_arbiter_if;
  // ibus requester (read-only)
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  // dbus requester (read/write)
  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  // shared Wishbone port
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  // forced-termination pulse
  logic        o_timeout;

  modport master (
    input  i_ibus_adr, i_ibus_cyc,
    output o_ibus_rdt, o_ibus_ack,
    input  i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
    output o_dbus_rdt, o_dbus_ack,
    output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
    input  i_wb_rdt, i_wb_ack,
    output o_timeout
  );

  modport slave (
    output i_ibus_adr, i_ibus_cyc,
    input  o_ibus_rdt, o_ibus_ack,
    output i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
    input  o_dbus_rdt, o_dbus_ack,
    input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
    output i_wb_rdt, i_wb_ack,
    input  o_timeout
  );
endinterface

// File: rtl/serv_wb_arbiter.sv
// serv_wb_arbiter: shares one Wishbone master port between the SERV instruction
// bus and data bus. One requester is granted at a time, and the grant is held
// until an ack arrives or the requester drops cyc. Simultaneous requests
// alternate round-robin. At least one IDLE cycle follows every completion, so
// a stale cyc is never re-granted.
// Optional feature: define SERV_WB_ARB_TIMEOUT_EN to add a watchdog. The
// watchdog force-acks a granted transaction after TIMEOUT_CYCLES cycles
// without an ack. It returns rdt = 32'hFFFFFFFF and pulses o_timeout.
module serv_wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   i_rst,
  serv_wb_arbiter_if.master      bus
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  typedef enum logic {REQ_IBUS, REQ_DBUS} req_t;

  state_t state, next_state;
  req_t   last_grant;
  logic   timeout_hit;

  // Reject watchdog lengths the 16-bit counter cannot express.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("serv_wb_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

`ifdef SERV_WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] count;

  // Watchdog counter: zero whenever idle, so each grant starts from 0.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)                 count <= '0;
    else if (state == IDLE)    count <= '0;
    else if (!bus.i_wb_ack)    count <= count + 16'd1;
  end

  // A real ack in the final cycle wins over the forced termination.
  assign timeout_hit = (state != IDLE) && !bus.i_wb_ack && (count == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // State and round-robin history register.
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples pre-edge values, whatever order the always blocks run in.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      last_grant <= REQ_DBUS;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == GNT_I) last_grant <= REQ_IBUS;
      if (state == IDLE && next_state == GNT_D) last_grant <= REQ_DBUS;
    end
  end

  // Next-state selection: tie goes to whoever was not granted last.
  // NOTE: every variable gets a default before the case statement, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (bus.i_ibus_cyc && bus.i_dbus_cyc)
          next_state = (last_grant == REQ_IBUS) ? GNT_D : GNT_I;
        else if (bus.i_ibus_cyc)
          next_state = GNT_I;
        else if (bus.i_dbus_cyc)
          next_state = GNT_D;
      end
      GNT_I: if (bus.i_wb_ack || timeout_hit || !bus.i_ibus_cyc) next_state = IDLE;
      GNT_D: if (bus.i_wb_ack || timeout_hit || !bus.i_dbus_cyc) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bus mux and ack steering. The output fields depend only on the current grant.
  always_comb begin
    bus.o_wb_adr   = '0;
    bus.o_wb_dat   = '0;
    bus.o_wb_sel   = '0;
    bus.o_wb_we    = 1'b0;
    bus.o_wb_cyc   = 1'b0;
    bus.o_ibus_ack = 1'b0;
    bus.o_dbus_ack = 1'b0;
    unique case (state)
      GNT_I: begin
        bus.o_wb_adr   = bus.i_ibus_adr;
        bus.o_wb_sel   = 4'hF;
        bus.o_wb_cyc   = bus.i_ibus_cyc;
        bus.o_ibus_ack = bus.i_wb_ack || timeout_hit;
      end
      GNT_D: begin
        bus.o_wb_adr   = bus.i_dbus_adr;
        bus.o_wb_dat   = bus.i_dbus_dat;
        bus.o_wb_sel   = bus.i_dbus_sel;
        bus.o_wb_we    = bus.i_dbus_we;
        bus.o_wb_cyc   = bus.i_dbus_cyc;
        bus.o_dbus_ack = bus.i_wb_ack || timeout_hit;
      end
      default: ;
    endcase
  end

  // Read data is shared and unqualified; the requesters qualify it with their ack.
  assign bus.o_ibus_rdt = timeout_hit ? 32'hFFFF_FFFF : bus.i_wb_rdt;
  assign bus.o_dbus_rdt = timeout_hit ? 32'hFFFF_FFFF : bus.i_wb_rdt;
  assign bus.o_timeout  = timeout_hit;

endmodule

// File: tb/tb_serv_wb_arbiter.sv
// Bench for serv_wb_arbiter. A transaction-level owner model predicts every
// output on each falling edge. Directed sequences cover single reads and
// writes, round-robin ties, abort, async reset and the stall or timeout path.
// Literal checks in those sequences pin the model.
module tb_serv_wb_arbiter;
  localparam int TIMEOUT = 4;
`ifdef SERV_WB_ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  serv_wb_arbiter_if bus();

  serv_wb_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk   (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus (0 none, 1 ibus, 2 dbus), who owned it last,
  // and how many granted cycles have passed without an ack.
  int owner = 0;
  int last_owner = 2;
  int waited = 0;

  function automatic logic model_own_cyc();
    if (owner == 1) return bus.i_ibus_cyc;
    if (owner == 2) return bus.i_dbus_cyc;
    return 1'b0;
  endfunction

  function automatic logic model_hit();
    return TO_ON && owner != 0 && !bus.i_wb_ack && waited == TIMEOUT - 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= 0;
      last_owner <= 2;
      waited <= 0;
    end else if (owner == 0) begin
      waited <= 0;
      if (bus.i_ibus_cyc && bus.i_dbus_cyc) begin
        owner <= (last_owner == 1) ? 2 : 1;
        last_owner <= (last_owner == 1) ? 2 : 1;
      end else if (bus.i_ibus_cyc) begin
        owner <= 1;
        last_owner <= 1;
      end else if (bus.i_dbus_cyc) begin
        owner <= 2;
        last_owner <= 2;
      end
    end else begin
      if (bus.i_wb_ack || model_hit() || !model_own_cyc()) owner <= 0;
      else waited <= waited + 1;
    end
  end

  // Compare process: every output checked against the model each falling edge.
  always @(negedge clk) begin
    logic hit;
    hit = model_hit();
    check("wb_adr", bus.o_wb_adr, owner == 1 ? bus.i_ibus_adr : owner == 2 ? bus.i_dbus_adr : 32'h0);
    check("wb_dat", bus.o_wb_dat, owner == 2 ? bus.i_dbus_dat : 32'h0);
    check("wb_sel", {28'h0, bus.o_wb_sel}, owner == 1 ? 32'hF : owner == 2 ? {28'h0, bus.i_dbus_sel} : 32'h0);
    check("wb_we", {31'h0, bus.o_wb_we}, {31'h0, owner == 2 && bus.i_dbus_we});
    check("wb_cyc", {31'h0, bus.o_wb_cyc}, {31'h0, model_own_cyc()});
    check("ibus_ack", {31'h0, bus.o_ibus_ack}, {31'h0, owner == 1 && (bus.i_wb_ack || hit)});
    check("dbus_ack", {31'h0, bus.o_dbus_ack}, {31'h0, owner == 2 && (bus.i_wb_ack || hit)});
    check("ibus_rdt", bus.o_ibus_rdt, hit ? 32'hFFFF_FFFF : bus.i_wb_rdt);
    check("dbus_rdt", bus.o_dbus_rdt, hit ? 32'hFFFF_FFFF : bus.i_wb_rdt);
    check("timeout", {31'h0, bus.o_timeout}, {31'h0, hit});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_ibus_cyc = 1'b0;
    bus.i_dbus_cyc = 1'b0;
    bus.i_wb_ack   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_ibus_adr = '0; bus.i_ibus_cyc = 1'b0;
    bus.i_dbus_adr = '0; bus.i_dbus_dat = '0; bus.i_dbus_sel = '0;
    bus.i_dbus_we = 1'b0; bus.i_dbus_cyc = 1'b0;
    bus.i_wb_rdt = 32'hDEAD_0001; bus.i_wb_ack = 1'b0;
    tick();
    check("rst_cyc", {31'h0, bus.o_wb_cyc}, 32'h0);
    check("rst_timeout", {31'h0, bus.o_timeout}, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Single ibus read, acked two cycles after cyc rises.
    bus.i_ibus_adr = 32'h100; bus.i_ibus_cyc = 1'b1;
    tick();
    check("i_rd_adr", bus.o_wb_adr, 32'h100);
    check("i_rd_sel", {28'h0, bus.o_wb_sel}, 32'hF);
    check("i_rd_cyc", {31'h0, bus.o_wb_cyc}, 32'h1);
    tick();
    tick();
    bus.i_wb_ack = 1'b1; bus.i_wb_rdt = 32'h1234_5678;
    #1;
    check("i_rd_ack", {31'h0, bus.o_ibus_ack}, 32'h1);
    check("i_rd_rdt", bus.o_ibus_rdt, 32'h1234_5678);
    check("i_rd_dack", {31'h0, bus.o_dbus_ack}, 32'h0);
    tick();
    idle_inputs();
    #1;
    check("i_rd_idle", {31'h0, bus.o_wb_cyc}, 32'h0);
    tick();

    // Single dbus write.
    bus.i_dbus_adr = 32'h2000; bus.i_dbus_dat = 32'hCAFE_BABE;
    bus.i_dbus_sel = 4'h3; bus.i_dbus_we = 1'b1; bus.i_dbus_cyc = 1'b1;
    tick();
    check("d_wr_adr", bus.o_wb_adr, 32'h2000);
    check("d_wr_dat", bus.o_wb_dat, 32'hCAFE_BABE);
    check("d_wr_sel", {28'h0, bus.o_wb_sel}, 32'h3);
    check("d_wr_we", {31'h0, bus.o_wb_we}, 32'h1);
    bus.i_wb_ack = 1'b1;
    #1;
    check("d_wr_ack", {31'h0, bus.o_dbus_ack}, 32'h1);
    check("d_wr_iack", {31'h0, bus.o_ibus_ack}, 32'h0);
    tick();
    idle_inputs();
    bus.i_dbus_we = 1'b0;
    #1;
    check("d_wr_idle", {31'h0, bus.o_wb_cyc}, 32'h0);
    tick();

    // Simultaneous requests after reset: ibus, then dbus, then ibus again.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_ibus_adr = 32'h300; bus.i_dbus_adr = 32'h400; bus.i_dbus_sel = 4'hC;
    bus.i_ibus_cyc = 1'b1; bus.i_dbus_cyc = 1'b1;
    tick();
    check("rr1_adr", bus.o_wb_adr, 32'h300);
    bus.i_wb_ack = 1'b1;
    tick();
    bus.i_wb_ack = 1'b0;
    #1;
    check("rr1_idle", {31'h0, bus.o_wb_cyc}, 32'h0);
    tick();
    check("rr2_adr", bus.o_wb_adr, 32'h400);
    bus.i_wb_ack = 1'b1;
    tick();
    bus.i_wb_ack = 1'b0;
    tick();
    check("rr3_adr", bus.o_wb_adr, 32'h300);
    bus.i_wb_ack = 1'b1;
    tick();
    idle_inputs();
    tick();

    // Abort: ibus drops cyc before any ack; a late ack in IDLE is ignored.
    bus.i_ibus_adr = 32'h700; bus.i_ibus_cyc = 1'b1;
    tick();
    check("ab_cyc", {31'h0, bus.o_wb_cyc}, 32'h1);
    bus.i_ibus_cyc = 1'b0;
    #1;
    check("ab_drop", {31'h0, bus.o_wb_cyc}, 32'h0);
    tick();
    bus.i_wb_ack = 1'b1;
    #1;
    check("ab_late_iack", {31'h0, bus.o_ibus_ack}, 32'h0);
    check("ab_late_dack", {31'h0, bus.o_dbus_ack}, 32'h0);
    tick();
    idle_inputs();
    tick();

    // Async reset while dbus is granted.
    bus.i_dbus_adr = 32'h800; bus.i_dbus_cyc = 1'b1;
    tick();
    check("ar_cyc", {31'h0, bus.o_wb_cyc}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_drop", {31'h0, bus.o_wb_cyc}, 32'h0);
    bus.i_dbus_cyc = 1'b0;
    tick();
    rst = 1'b0;
    bus.i_ibus_adr = 32'h500; bus.i_ibus_cyc = 1'b1;
    tick();
    check("ar_regrant", bus.o_wb_adr, 32'h500);
    bus.i_wb_ack = 1'b1;
    tick();
    idle_inputs();
    tick();

    // Missing ack: forced termination when the watchdog is built in, stall otherwise.
    bus.i_dbus_adr = 32'h600; bus.i_dbus_sel = 4'hF; bus.i_dbus_cyc = 1'b1;
    bus.i_wb_rdt = 32'h5555_AAAA;
    tick();
    tick();
    tick();
    tick();
    if (TO_ON) begin
      check("to_ack", {31'h0, bus.o_dbus_ack}, 32'h1);
      check("to_rdt", bus.o_dbus_rdt, 32'hFFFF_FFFF);
      check("to_pulse", {31'h0, bus.o_timeout}, 32'h1);
      tick();
      bus.i_dbus_cyc = 1'b0;
      #1;
      check("to_idle", {31'h0, bus.o_wb_cyc}, 32'h0);
      check("to_pulse_end", {31'h0, bus.o_timeout}, 32'h0);
      tick();
      bus.i_dbus_cyc = 1'b1;
      tick();
      tick();
      tick();
      tick();
      bus.i_wb_ack = 1'b1; bus.i_wb_rdt = 32'hA5A5_A5A5;
      #1;
      check("to_real_ack", {31'h0, bus.o_dbus_ack}, 32'h1);
      check("to_real_rdt", bus.o_dbus_rdt, 32'hA5A5_A5A5);
      check("to_real_pulse", {31'h0, bus.o_timeout}, 32'h0);
      tick();
    end else begin
      tick();
      tick();
      check("stall_cyc", {31'h0, bus.o_wb_cyc}, 32'h1);
      check("stall_ack", {31'h0, bus.o_dbus_ack}, 32'h0);
      check("stall_pulse", {31'h0, bus.o_timeout}, 32'h0);
      bus.i_wb_ack = 1'b1;
      #1;
      check("stall_done", {31'h0, bus.o_dbus_ack}, 32'h1);
      tick();
    end
    idle_inputs();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
